// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//   Parallel-to-serial framing transmitter. A Data_width-bit word is accepted
//   over a Valid/Ready handshake and sent on TxOut as a framed serial stream:
//   start bit (0), data LSB first, stop bit (1). Each bit is held for
//   Clks_per_bit clocks. It feeds serial links and the LeftIn input of the
//   downstream shift stages.
//
// Parameters:
//   Data_width   : width of the parallel word (>= 2)
//   Clks_per_bit : clocks each serial bit is held (>= 1)
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   asynchronous, active-high reset
//   D     in   parallel word, sampled only on the accept edge
//   Valid in   upstream has a word on D
//   Ready out  high only while IDLE (decoded from registered state)
//   TxOut out  registered serial line, idles at 1
//   Busy  out  high while a frame is in progress
//   Done  out  one-cycle pulse after the stop bit completes
//
// Optional feature:
//   SERIAL_FRAME_TX_PARITY_EN - when defined, an even-parity bit is sent
//   between the last data bit and the stop bit.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int Data_width   = 5,
  parameter int Clks_per_bit = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_width-1:0] D,
  input  logic                  Valid,
  output logic                  Ready,
  output logic                  TxOut,
  output logic                  Busy,
  output logic                  Done
);

  // A one-clock bit still needs a 1-bit counter to keep the ports legal.
  localparam int CW = (Clks_per_bit > 1) ? $clog2(Clks_per_bit) : 1;
  localparam int BW = $clog2(Data_width);
  localparam logic [CW-1:0] CYC_LAST = CW'(Clks_per_bit - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(Data_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [Data_width-1:0] word);
    return ^word;
  endfunction
`endif

  state_t                state_r, state_s;
  logic                  tx_r, tx_s;
  logic                  done_r, done_s;
  logic [Data_width-1:0] sr_r, sr_s;
  logic [BW-1:0]         bit_cnt_r, bit_cnt_s;
  logic [CW-1:0]         cyc_cnt_r, cyc_cnt_s;
  logic                  bit_end_s;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  // Parity is taken from D at accept time because the shift register
  // is consumed while the data bits go out.
  logic                  par_r, par_s;
`endif

  assign bit_end_s = (cyc_cnt_r == CYC_LAST);

  // Next-state and next-output decode for the framing FSM.
  always_comb begin
    state_s   = state_r;
    tx_s      = tx_r;
    done_s    = 1'b0;
    sr_s      = sr_r;
    bit_cnt_s = bit_cnt_r;
    cyc_cnt_s = cyc_cnt_r;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_s     = par_r;
`endif
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (Valid) begin
          // Start bit goes out on the accept edge itself.
          sr_s      = D;
          cyc_cnt_s = '0;
          bit_cnt_s = '0;
          state_s   = START;
          tx_s      = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_s     = even_parity(D);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cyc_cnt_s = '0;
          state_s   = DATA;
          tx_s      = sr_r[0];
        end else begin
          cyc_cnt_s = cyc_cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cyc_cnt_s = '0;
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_s = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_s   = PARITY;
            tx_s      = par_r;
`else
            state_s   = STOP;
            tx_s      = 1'b1;
`endif
          end else begin
            // Next data bit is the current bit 1, i.e. bit 0 after the shift.
            sr_s      = {1'b0, sr_r[Data_width-1:1]};
            tx_s      = sr_r[1];
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          cyc_cnt_s = cyc_cnt_r + CW'(1);
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          cyc_cnt_s = '0;
          state_s   = STOP;
          tx_s      = 1'b1;
        end else begin
          cyc_cnt_s = cyc_cnt_r + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          cyc_cnt_s = '0;
          state_s   = IDLE;
          tx_s      = 1'b1;
          done_s    = 1'b1;
        end else begin
          cyc_cnt_s = cyc_cnt_r + CW'(1);
        end
      end
      default: begin
        state_s   = IDLE;
        tx_s      = 1'b1;
        cyc_cnt_s = '0;
        bit_cnt_s = '0;
      end
    endcase
  end

  // State and output registers; RST abandons any frame in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
      sr_r      <= '0;
      bit_cnt_r <= '0;
      cyc_cnt_r <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      tx_r      <= tx_s;
      done_r    <= done_s;
      sr_r      <= sr_s;
      bit_cnt_r <= bit_cnt_s;
      cyc_cnt_r <= cyc_cnt_s;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_r     <= par_s;
`endif
    end
  end

  assign Ready = (state_r == IDLE);
  assign Busy  = (state_r != IDLE);
  assign TxOut = tx_r;
  assign Done  = done_r;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//   Directed bench for serial_frame_tx. u_dut0 uses the default timing
//   (Clks_per_bit=4), u_dut1 uses the minimum (Clks_per_bit=1). Expected line
//   levels are pushed to a queue when a word is offered and popped one per
//   cycle while the frame is on the line.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

  localparam int W   = 5;
  localparam int CPB = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NB  = W + 3;
`else
  localparam int NB  = W + 2;
`endif
  localparam int FCYC = NB * CPB;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d0, d1;
  logic         v0, v1;
  logic         rdy0, tx0, busy0, done0;
  logic         rdy1, tx1, busy1, done1;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  bit exp1_q[$];

  always #5 clk = ~clk;

  serial_frame_tx #(.Data_width(W), .Clks_per_bit(CPB)) u_dut0 (
    .CLK(clk), .RST(rst), .D(d0), .Valid(v0),
    .Ready(rdy0), .TxOut(tx0), .Busy(busy0), .Done(done0)
  );

  serial_frame_tx #(.Data_width(W), .Clks_per_bit(1)) u_dut1 (
    .CLK(clk), .RST(rst), .D(d1), .Valid(v1),
    .Ready(rdy1), .TxOut(tx1), .Busy(busy1), .Done(done1)
  );

  // Line levels of one frame, in transmit order (index 0 goes out first).
  function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] w);
    logic [NB-1:0] f;
    f    = '0;
    f[0] = 1'b0;
    for (int i = 0; i < W; i++) f[1+i] = w[i];
`ifdef SERIAL_FRAME_TX_PARITY_EN
    f[W+1] = ^w;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    logic [NB-1:0] f;
    f = frame_bits(w);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(f[b]);
  endtask

  // Called right after the accept edge. Checks every cycle of the frame on
  // u_dut0, then the Done cycle. After the first sample Valid/D take
  // v_mid/d_mid, and halfway through D is scrambled.
  task automatic drain_frame(input string tag, input logic [W-1:0] d_mid,
                             input logic v_mid);
    logic e;
    for (int k = 0; k < FCYC; k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 1'bx;
      chk({tag, "_tx"}, tx0, e);
      chk({tag, "_busy"}, busy0, 1'b1);
      chk({tag, "_ready"}, rdy0, 1'b0);
      chk({tag, "_done_early"}, done0, 1'b0);
      if (k == 0) begin
        d0 = d_mid;
        v0 = v_mid;
      end else if (k == FCYC / 2) begin
        d0 = W'($urandom);
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, done0, 1'b1);
    chk({tag, "_busy_end"}, busy0, 1'b0);
    chk({tag, "_ready_end"}, rdy0, 1'b1);
    chk({tag, "_tx_end"}, tx0, 1'b1);
  endtask

  initial begin
    logic          e;
    logic [NB-1:0] f;

    rst = 1'b1;
    d0  = '0;
    v0  = 1'b0;
    d1  = '0;
    v1  = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    rst = 1'b0;

    // 1. Idle after reset release.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_tx", tx0, 1'b1);
      chk("idle_ready", rdy0, 1'b1);
      chk("idle_busy", busy0, 1'b0);
      chk("idle_done", done0, 1'b0);
      chk("idle_tx1", tx1, 1'b1);
    end

    // 2. Single frame 10110.
    d0 = 5'b10110;
    v0 = 1'b1;
    push_frame(d0);
    @(posedge clk);
    drain_frame("single", 5'b00000, 1'b0);
    @(negedge clk);
    chk("single_done_pulse", done0, 1'b0);
    chk("single_idle_tx", tx0, 1'b1);

    // 3. Back-to-back with Valid held high through the first frame.
    d0 = 5'b00001;
    v0 = 1'b1;
    push_frame(d0);
    @(posedge clk);
    drain_frame("b2b1", 5'b11110, 1'b1);
    d0 = 5'b11110;
    v0 = 1'b1;
    push_frame(d0);
    @(posedge clk);
    drain_frame("b2b2", 5'b00000, 1'b0);
    @(negedge clk);
    chk("b2b_done_pulse", done0, 1'b0);

    // 4. Asynchronous reset during the third data bit (a 0 for 10010).
    d0 = 5'b10010;
    v0 = 1'b1;
    push_frame(d0);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (13) @(negedge clk);
    chk("mid_tx_before_rst", tx0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx0, 1'b1);
    chk("async_rst_ready", rdy0, 1'b1);
    chk("async_rst_busy", busy0, 1'b0);
    chk("async_rst_done", done0, 1'b0);
    exp_q.delete();
    #1 rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", done0, 1'b0);
      chk("post_rst_tx", tx0, 1'b1);
    end
    d0 = 5'b01101;
    v0 = 1'b1;
    push_frame(d0);
    @(posedge clk);
    drain_frame("after_rst", 5'b00000, 1'b0);

    // 5. Minimum timing on u_dut1: one bit per clock.
    @(negedge clk);
    d1 = 5'b01010;
    v1 = 1'b1;
    f  = frame_bits(d1);
    for (int b = 0; b < NB; b++) exp1_q.push_back(f[b]);
    @(posedge clk);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      if (k == 0) v1 = 1'b0;
      if (exp1_q.size() > 0) e = exp1_q.pop_front();
      else e = 1'bx;
      chk("min_tx", tx1, e);
      chk("min_busy", busy1, 1'b1);
      chk("min_done_early", done1, 1'b0);
    end
    @(negedge clk);
    chk("min_done", done1, 1'b1);
    chk("min_ready", rdy1, 1'b1);
    @(negedge clk);
    chk("min_done_pulse", done1, 1'b0);

    // 6. Second parity pattern (even count of ones) on u_dut0.
    d0 = 5'b10100;
    v0 = 1'b1;
    push_frame(d0);
    @(posedge clk);
    drain_frame("par0", 5'b00000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
